// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared constants, state encoding and helpers for the 4-requester round-robin arbiter.
package mux4_arb_pkg;

  localparam int unsigned NUM_REQ    = 4;
  localparam int unsigned IDX_W      = 2;
  localparam int unsigned DEF_DATA_W = 64;

  typedef enum logic {
    IDLE = 1'b0,
    FULL = 1'b1
  } state_t;

  function automatic logic [NUM_REQ-1:0] idx2oh(input logic [IDX_W-1:0] idx);
    idx2oh      = '0;
    idx2oh[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/mux4_rr_arbiter_if.sv
// Requester/consumer bundle of the round-robin arbiter; the lock vector exists only
// when ARB_LOCK_EN is defined.
interface mux4_arb_if #(
  parameter int unsigned DATA_W = 64
);
  logic [3:0]        req;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic [DATA_W-1:0] c;
  logic [DATA_W-1:0] d;
  logic [3:0]        gnt;
  logic [1:0]        sel;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;
`ifdef ARB_LOCK_EN
  logic [3:0]        lock;
`endif

  // Arbiter side
  modport slave (
    input  req, a, b, c, d, out_ready,
`ifdef ARB_LOCK_EN
    input  lock,
`endif
    output gnt, sel, out_valid, out_data
  );

  // Producer/consumer side
  modport master (
    output req, a, b, c, d, out_ready,
`ifdef ARB_LOCK_EN
    output lock,
`endif
    input  gnt, sel, out_valid, out_data
  );

endinterface

// File: rtl/mux4_rr_arbiter_mux.sv
// Plain 4:1 word select shared by all requesters.
module mux_4_in #(
  parameter int unsigned DATA_W = 64
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] c,
  input  logic [DATA_W-1:0] d,
  input  logic [1:0]        sel,
  output logic [DATA_W-1:0] y
);

  always_comb begin
    y = '0;
    unique case (sel)
      2'd0: y = a;
      2'd1: y = b;
      2'd2: y = c;
      2'd3: y = d;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/mux4_rr_arbiter_rr_pick.sv
// Combinational round-robin pick: first requester after `last`, wrapping 3 -> 0.
module rr_pick
  import mux4_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic [IDX_W-1:0]   pick,
  output logic               any
);

  logic [2*NUM_REQ-1:0] w_dbl;
  logic [2*NUM_REQ-1:0] w_shifted;
  logic [IDX_W:0]       w_sh;
  logic [NUM_REQ-1:0]   w_rot;
  logic [IDX_W-1:0]     w_off;
  logic                 w_found;

  // Rotate so bit 0 is the requester right after `last`, then take the lowest set bit.
  assign w_dbl     = {req, req};
  assign w_sh      = {1'b0, last} + 3'd1;
  assign w_shifted = w_dbl >> w_sh;
  assign w_rot     = w_shifted[NUM_REQ-1:0];

  always_comb begin
    w_off   = '0;
    w_found = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (w_rot[i] && !w_found) begin
        w_off   = i[IDX_W-1:0];
        w_found = 1'b1;
      end
    end
  end

  assign pick = last + 2'd1 + w_off;
  assign any  = |req;

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter driving a shared 4:1 select into a one-entry valid/ready buffer.
// Define ARB_LOCK_EN to let the last-granted requester hold the grant with lock[].
module mux4_rr_arbiter
  import mux4_arb_pkg::*;
#(
  parameter int unsigned      DATA_W  = DEF_DATA_W,
  parameter logic [IDX_W-1:0] RST_PTR = 2'd3
) (
  input logic       clk,
  input logic       reset,
  mux4_arb_if.slave bus
);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [IDX_W-1:0]   r_last;
  logic [IDX_W-1:0]   r_sel;
  logic [IDX_W-1:0]   w_rr_pick;
  logic [IDX_W-1:0]   w_pick;
  logic [IDX_W-1:0]   w_sel;
  logic [NUM_REQ-1:0] r_gnt;
  logic [DATA_W-1:0]  r_data;
  logic [DATA_W-1:0]  w_mux;
  logic               w_any;
  logic               w_can_load;
  logic               w_load;

  rr_pick u_rr_pick (
    .req  (bus.req),
    .last (r_last),
    .pick (w_rr_pick),
    .any  (w_any)
  );

`ifdef ARB_LOCK_EN
  assign w_pick = (bus.lock[r_last] && bus.req[r_last]) ? r_last : w_rr_pick;
`else
  assign w_pick = w_rr_pick;
`endif

  assign w_sel = w_any ? w_pick : r_sel;

  mux_4_in #(.DATA_W(DATA_W)) u_mux (
    .a   (bus.a),
    .b   (bus.b),
    .c   (bus.c),
    .d   (bus.d),
    .sel (w_sel),
    .y   (w_mux)
  );

  // out_valid is exactly state==FULL, so "out_valid && out_ready" reduces to out_ready here.
  assign w_can_load = (r_state == IDLE) || bus.out_ready;
  assign w_load     = w_can_load && w_any;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_can_load) w_state_nxt = w_any ? FULL : IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data <= '0;
      r_gnt  <= '0;
      r_last <= RST_PTR;
      r_sel  <= '0;
    end else begin
      r_sel <= w_sel;
      r_gnt <= w_load ? idx2oh(w_pick) : '0;
      if (w_load) begin
        r_data <= w_mux;
        r_last <= w_pick;
      end
    end
  end

  assign bus.gnt       = r_gnt;
  assign bus.sel       = w_sel;
  assign bus.out_valid = (r_state == FULL);
  assign bus.out_data  = r_data;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Randomized and directed bench for mux4_rr_arbiter against a transaction-level model.
module tb_mux4_rr_arbiter;

  logic clk;
  logic reset;

  mux4_arb_if #(.DATA_W(64)) bus ();

  mux4_rr_arbiter #(.DATA_W(64), .RST_PTR(2'd3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  // requester-side stimulus state
  logic [3:0]  pend;
  logic [63:0] word [4];
  logic        ready;
`ifdef ARB_LOCK_EN
  logic [3:0]  m_lock;
`endif

  // reference model state
  bit          m_valid;
  logic [63:0] m_data;
  logic [3:0]  m_gnt;
  int          m_last;
  int          m_sel;
  int          waits [4];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int mpick(input logic [3:0] r, input int last);
`ifdef ARB_LOCK_EN
    if (r[last] && m_lock[last]) return last;
`endif
    for (int k = 1; k <= 4; k++)
      if (r[(last + k) % 4]) return (last + k) % 4;
    return -1;
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic drive();
    bus.req       = pend;
    bus.a         = word[0];
    bus.b         = word[1];
    bus.c         = word[2];
    bus.d         = word[3];
    bus.out_ready = ready;
`ifdef ARB_LOCK_EN
    bus.lock      = m_lock;
`endif
  endtask

  task automatic model_reset();
    m_valid = 0;
    m_data  = '0;
    m_gnt   = '0;
    m_last  = 3;
    m_sel   = 0;
    for (int i = 0; i < 4; i++) waits[i] = 0;
  endtask

  // Call right after a falling edge with inputs driven; returns at the next falling edge.
  task automatic tick();
    int p;
    #1;
    p = mpick(pend, m_last);
    if (p >= 0) m_sel = p;
    check_eq("sel", 64'(bus.sel), 64'(m_sel));
    if (!m_valid || ready) begin
      if (p >= 0) begin
        m_data = word[p];
        m_valid = 1;
        m_gnt = '0;
        m_gnt[p] = 1'b1;
        m_last = p;
      end else begin
        m_valid = 0;
        m_gnt = '0;
      end
    end else begin
      m_gnt = '0;
    end
    @(negedge clk);
    check_eq("valid", 64'(bus.out_valid), 64'(m_valid));
    check_eq("gnt", 64'(bus.gnt), 64'(m_gnt));
    if (m_valid) check_eq("data", bus.out_data, m_data);
`ifndef ARB_LOCK_EN
    for (int i = 0; i < 4; i++) begin
      if (bus.gnt[i]) begin
        check_eq("fair", 64'(waits[i] <= 3), 64'd1);
        waits[i] = 0;
      end else if (pend[i] && bus.gnt != 4'b0) begin
        waits[i]++;
      end else if (!pend[i]) begin
        waits[i] = 0;
      end
    end
`endif
  endtask

  // Granted requesters present a fresh word (or, if rand_drop, may go idle).
  task automatic refill(input bit rand_drop);
    for (int i = 0; i < 4; i++) begin
      if (m_gnt[i]) begin
        pend[i] = rand_drop ? ($urandom_range(3) != 0) : 1'b1;
        word[i] = rnd64();
      end
    end
  endtask

  task automatic reset_checks(input string tag);
    #1;
    check_eq({tag, "_valid"}, 64'(bus.out_valid), 64'd0);
    check_eq({tag, "_gnt"}, 64'(bus.gnt), 64'd0);
    check_eq({tag, "_data"}, bus.out_data, 64'd0);
  endtask

  logic [63:0] frozen;

  initial begin
    reset = 1'b1;
    pend  = 4'b1111;
    ready = 1'b1;
    for (int i = 0; i < 4; i++) word[i] = rnd64();
`ifdef ARB_LOCK_EN
    m_lock = 4'b0000;
`endif
    drive();
    model_reset();

    // reset held with all requests pending
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      reset_checks("rst");
    end
    @(negedge clk);
    reset = 1'b0;

    // full load, always ready: strict rotation 0,1,2,3,0...
    for (int k = 0; k < 8; k++) begin
      drive();
      tick();
      check_eq("rot", 64'(bus.gnt), 64'(4'b0001 << (k % 4)));
      refill(1'b0);
    end

    // wrap from last=3 with requesters 0 and 3
    pend = 4'b1001;
    drive(); tick();
    check_eq("wrap0", 64'(bus.gnt), 64'(4'b0001));
    refill(1'b0);
    pend = 4'b1001;
    drive(); tick();
    check_eq("wrap3", 64'(bus.gnt), 64'(4'b1000));

    // drain, then a lone request from requester 2
    pend = 4'b0000;
    drive(); tick();
    check_eq("drained", 64'(bus.out_valid), 64'd0);
    pend = 4'b0100;
    word[2] = 64'hDEAD_BEEF;
    drive(); tick();
    check_eq("solo_gnt", 64'(bus.gnt), 64'(4'b0100));
    check_eq("solo_data", bus.out_data, 64'hDEAD_BEEF);
    check_eq("solo_valid", 64'(bus.out_valid), 64'd1);
    pend = 4'b0000;

    // backpressure with requesters 0 and 1
    pend = 4'b0011;
    drive(); tick();
    frozen = bus.out_data;
    check_eq("bp_first", 64'(bus.gnt), 64'(4'b0001));
    refill(1'b0);
    ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      drive(); tick();
      check_eq("bp_gnt", 64'(bus.gnt), 64'd0);
      check_eq("bp_frz", bus.out_data, frozen);
    end
    ready = 1'b1;
    drive(); tick();
    check_eq("bp_next", 64'(bus.gnt), 64'(4'b0010));
    refill(1'b0);

    // reset while the buffer is full
    ready = 1'b0;
    pend  = 4'b1111;
    drive(); tick();
    check_eq("pre_rst_full", 64'(bus.out_valid), 64'd1);
    reset = 1'b1;
    reset_checks("midrst");
    model_reset();
    @(negedge clk);
    reset_checks("midrst_hold");
    reset = 1'b0;
    ready = 1'b1;
    pend  = 4'b1111;
`ifdef ARB_LOCK_EN
    m_lock = 4'b0010;
`endif
    drive(); tick();
    check_eq("post_rst", 64'(bus.gnt), 64'(4'b0001));
    refill(1'b0);
    for (int k = 0; k < 3; k++) begin
      drive(); tick();
`ifdef ARB_LOCK_EN
      check_eq("lock", 64'(bus.gnt), 64'(4'b0010));
`else
      check_eq("post_rot", 64'(bus.gnt), 64'(4'b0010 << k));
`endif
      refill(1'b0);
    end

    // randomized traffic and backpressure
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < 4; i++) begin
        if (!pend[i] && !m_gnt[i] && $urandom_range(2) == 0) begin
          pend[i] = 1'b1;
          word[i] = rnd64();
        end
      end
      ready = ($urandom_range(3) != 0);
`ifdef ARB_LOCK_EN
      m_lock = 4'($urandom_range(15));
`endif
      drive();
      tick();
      refill(1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
